mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-port arbiter sharing the single simulation memory's valid/ready native bus between the picorv32 core (port 0) and a host-side debug/loader requester (port 1). It sits between the requesters and the testbench memory/console decode. It grants one whole transaction at a time in round-robin order. An optional watchdog aborts transactions the memory never acknowledges.

## Interface

- TIMEOUT_CYCLES, 64: cycles a granted transaction may wait for s_ready before abort (macro-enabled only); legal range 2..65535.
- RR_RESET_LAST, 1: index treated as "last granted" after reset; the default gives port 0 first win.

- clk  in  1  clock; all state on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- m0_valid, m0_instr  in  1 each  core request, instruction-fetch flag.
- m0_addr, m0_wdata  in  32 each  core address, write data.
- m0_wstrb  in  4  core byte strobes; 0 = read.
- m0_ready  out  1  core transaction complete.
- m0_rdata  out  32  core read data.
- m1_valid  in  1  host request.
- m1_addr, m1_wdata  in  32 each  host address, write data.
- m1_wstrb  in  4  host byte strobes.
- m1_ready  out  1  host transaction complete.
- m1_rdata  out  32  host read data.
- s_valid, s_instr  out  1 each  memory request; s_instr = m0_instr when port 0 granted, else 0.
- s_addr, s_wdata  out  32 each  muxed address, write data.
- s_wstrb  out  4  muxed strobes.
- s_ready  in  1  memory acknowledge.
- s_rdata  in  32  memory read data.
- grant  out  2  one-hot current grant (bit0 = port 0); 2'b00 when idle.
- timeout  out  1  one-cycle pulse on watchdog abort.

## Operation

- State machine: IDLE, GNT0, GNT1. Register `last` holds the most recently completed port.
- IDLE: only m0_valid -> GNT0; only m1_valid -> GNT1; both -> grant port != last; neither -> stay.
- GNTx: s_valid = mx_valid; s_addr/s_wdata/s_wstrb/s_instr muxed from port x. mx_ready = s_ready & s_valid. mx_rdata = s_rdata. The non-granted port sees ready 0 and rdata 0.
- Completion (s_valid & s_ready in GNTx): last <= x; next state IDLE.
- Granted master drops valid before ready (protocol violation): return to IDLE, `last` unchanged, no ready issued.
- Requesters hold valid and payload until ready; the arbiter does not register payload.
- Reset values: state IDLE, last = RR_RESET_LAST, grant 0, s_valid 0, m0_ready/m1_ready 0, timeout 0, watchdog counter 0. The outputs are forced to these values while resetn is low, so s_valid drops in the same cycle reset is sampled.

## Timing

- Grant latency: request seen in IDLE at edge N; s_valid is high from N+1.
- Memory response: zero-wait s_ready completes in the same cycle s_valid rises.
- Mandatory one-cycle IDLE bubble after each completion. Back-to-back transactions from alternating ports therefore take a minimum of 2 cycles each.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1...
- grant reflects the registered state; it changes only on clock edges.
- Reset mid-transaction: the partial transfer is discarded and no ready is issued. Memory writes already strobed by s_valid & s_ready are not undone.

## Configuration

- MEM_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to GNTx and increments each GNTx cycle without s_ready.
  - On the cycle the counter equals TIMEOUT_CYCLES-1 with s_ready still low, the arbiter:
    - asserts mx_ready with mx_rdata = 32'hDEADBEEF;
    - pulses timeout;
    - forces s_valid low next cycle;
    - sets last <= x and goes to IDLE.
  - s_ready arriving on that same cycle takes precedence: normal completion, no timeout pulse.
- MEM_ARB_TIMEOUT_EN undefined: no counter, the grant waits indefinitely, timeout is tied to 0.

## Test plan

- Single port-0 read, addr 0x100, s_ready high, s_rdata 0x12345678 -> s_valid one cycle after m0_valid; m0_ready the same cycle with rdata 0x12345678; grant 01 then 00.
- Both valid on the first cycle after reset -> port 0 served first, then port 1 after the one-cycle bubble; grant sequence 01, 00, 10.
- Both held valid for 8 transactions, s_ready always 1 -> grants alternate 0,1,0,1...; each transaction takes exactly 2 cycles.
- Port-1 write addr 0x10000000, wdata 0x41, wstrb 4'b0001 while m0 idle -> s_wstrb 0001, s_instr 0, m1_ready pulses once, m0_ready stays 0.
- (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64) port-0 read with s_ready stuck 0 -> m0_ready and timeout pulse on the 64th grant cycle, rdata 0xDEADBEEF; s_valid low on the following cycle. Without the macro, still waiting at cycle 200.
- resetn low for one cycle during GNT1 with s_ready 0 -> s_valid, grant and ready outputs 0 that cycle; after release, a pending m0 request is granted first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory bus between the core (port 0) and a host requester (port 1).
// Optional watchdog abort of unacknowledged transactions is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int RR_RESET_LAST = 1
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    // Handshake: a transfer completes on a cycle where s_valid and s_ready are both high;
    // requesters hold valid and payload stable until their ready pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_mvalid;
    logic   w_abort;
    logic   w_ack;
    logic [31:0] w_rdata;

    assign w_gnt0   = (r_state == ST_GNT0);
    assign w_gnt1   = (r_state == ST_GNT1);
    assign w_mvalid = (w_gnt0 & m0_valid) | (w_gnt1 & m1_valid);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] r_wd_cnt;

    assign w_abort = w_mvalid & ~s_ready & (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counter is zero on the first grant cycle and counts stalled grant cycles after that.
    always_ff @(posedge clk) begin
        if (!resetn || r_state == ST_IDLE || w_state_nxt == ST_IDLE) begin
            r_wd_cnt <= 16'd0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                end else if (m0_valid) begin
                    w_state_nxt = ST_GNT0;
                end else if (m1_valid) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                // A requester that abandons its request loses the grant without moving the pointer.
                if (!w_mvalid) begin
                    w_state_nxt = ST_IDLE;
                end else if (s_ready || w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = w_gnt1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_last  <= 1'(RR_RESET_LAST);
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign s_valid = resetn & w_mvalid;
    assign s_instr = resetn & w_gnt0 & m0_instr;
    assign s_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign s_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    assign s_wstrb = w_gnt1 ? m1_wstrb : m0_wstrb;

    assign w_ack   = s_valid & (s_ready | w_abort);
    assign w_rdata = w_abort ? 32'hDEAD_BEEF : s_rdata;

    assign m0_ready = w_ack & w_gnt0;
    assign m1_ready = w_ack & w_gnt1;
    assign m0_rdata = (resetn & w_gnt0) ? w_rdata : 32'd0;
    assign m1_rdata = (resetn & w_gnt1) ? w_rdata : 32'd0;
    assign grant    = resetn ? {w_gnt1, w_gnt0} : 2'b00;
    assign timeout  = resetn & w_abort;

endmodule
